// File: rtl/rpu_or_arb.sv
// rpu_or_arb: round-robin arbiter and single-entry output register for the
// RPU outbound-response path. NUM_REQ sources compete for one response slot
// that drives the outbound-response encoder until the NoC accepts it.
// A saturating counter tracks how many error responses have been accepted.
//
// Optional feature: define NOU_OR_ARB_ERR_PRIO_EN to give error responses
// (req_status=1) strict precedence over normal ones; the round-robin pointer
// is shared between both classes. Without it, arbitration ignores req_status.
//
// Handshake: req_vld[i] is held with its fields until req_ack[i]; the fields
// are sampled only in the ack cycle. ob_rsp_vld is held with stable fields
// until noc_rsp_rdy=1, which completes the transfer in that cycle.
// ob_rsp_vld is the FSM state itself (1 = SEND, 0 = IDLE).

`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 4
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TILE_ID_WIDTH
`define NOU_TILE_ID_WIDTH 6
`endif

module rpu_or_arb #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_vld,
  input  logic [NUM_REQ*`NOU_TYPE_WIDTH-1:0]     req_type,
  input  logic [NUM_REQ-1:0]                     req_status,
  input  logic [NUM_REQ*`NOU_ERR_CODE_WIDTH-1:0] req_err,
  input  logic [NUM_REQ*`NOU_TID_WIDTH-1:0]      req_tid,
  input  logic [NUM_REQ*`NOU_TILE_ID_WIDTH-1:0]  req_tile,
  output logic [NUM_REQ-1:0]                     req_ack,
  input  logic                                   noc_rsp_rdy,
  output logic                                   ob_rsp_vld,
  output logic [`NOU_TYPE_WIDTH-1:0]             ob_rsp_type,
  output logic                                   ob_rsp_status,
  output logic [`NOU_ERR_CODE_WIDTH-1:0]         ob_rsp_err,
  output logic [`NOU_TID_WIDTH-1:0]              cur_trans_id,
  output logic [`NOU_TILE_ID_WIDTH-1:0]          cur_dst_tile_id,
  output logic [CNT_W-1:0]                       err_rsp_cnt
);

  localparam int TW    = `NOU_TYPE_WIDTH;
  localparam int EW    = `NOU_ERR_CODE_WIDTH;
  localparam int IW    = `NOU_TID_WIDTH;
  localparam int LW    = `NOU_TILE_ID_WIDTH;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]        type_q, type_d;
  logic                 status_q, status_d;
  logic [EW-1:0]        err_q, err_d;
  logic [IW-1:0]        tid_q, tid_d;
  logic [LW-1:0]        tile_q, tile_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 can_grant;
  logic                 grant;
  logic                 accept;
  logic [PTR_W:0]       scan_idx;
  logic [TW-1:0]        type_sel;
  logic                 status_sel;
  logic [EW-1:0]        err_sel;
  logic [IW-1:0]        tid_sel;
  logic [LW-1:0]        tile_sel;

  // Candidate set: error class first when priority is enabled, else all requests.
  always_comb begin
    cand = req_vld;
`ifdef NOU_OR_ARB_ERR_PRIO_EN
    if (|(req_vld & req_status)) begin
      cand = req_vld & req_status;
    end
`endif
  end

  // Round-robin search: first candidate at ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!gnt_found && cand[scan_idx[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Select the granted source's fields and build the one-hot ack vector.
  always_comb begin
    type_sel   = '0;
    status_sel = 1'b0;
    err_sel    = '0;
    tid_sel    = '0;
    tile_sel   = '0;
    gnt_oh     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        gnt_oh[i]  = 1'b1;
        type_sel   = req_type[i*TW +: TW];
        status_sel = req_status[i];
        err_sel    = req_err[i*EW +: EW];
        tid_sel    = req_tid[i*IW +: IW];
        tile_sel   = req_tile[i*LW +: LW];
      end
    end
  end

  // Next-state logic: grant in IDLE or when the held response is accepted.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    type_d    = type_q;
    status_d  = status_q;
    err_d     = err_q;
    tid_d     = tid_q;
    tile_d    = tile_q;
    cnt_d     = cnt_q;
    accept    = (state_q == SEND) && noc_rsp_rdy;
    can_grant = (state_q == IDLE) || accept;
    grant     = can_grant && gnt_found;

    if (accept && status_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (grant) begin
      state_d  = SEND;
      type_d   = type_sel;
      status_d = status_sel;
      err_d    = err_sel;
      tid_d    = tid_sel;
      tile_d   = tile_sel;
      if (gnt_idx == PTR_W'(NUM_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PTR_W'(1);
      end
    end else if (accept) begin
      state_d = IDLE;
    end
  end

  // Ack is combinational and forced low while reset is asserted.
  always_comb begin
    req_ack = '0;
    if (rst_n && grant) begin
      req_ack = gnt_oh;
    end
  end

  // State, pointer, output register and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      type_q   <= '0;
      status_q <= 1'b0;
      err_q    <= '0;
      tid_q    <= '0;
      tile_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      type_q   <= type_d;
      status_q <= status_d;
      err_q    <= err_d;
      tid_q    <= tid_d;
      tile_q   <= tile_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ob_rsp_vld      = (state_q == SEND);
  assign ob_rsp_type     = type_q;
  assign ob_rsp_status   = status_q;
  assign ob_rsp_err      = err_q;
  assign cur_trans_id    = tid_q;
  assign cur_dst_tile_id = tile_q;
  assign err_rsp_cnt     = cnt_q;

endmodule

// File: tb/tb_rpu_or_arb.sv
// Bench for rpu_or_arb: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a transaction-level
// model (one held response, a round-robin pointer, a saturating count).

`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 4
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TILE_ID_WIDTH
`define NOU_TILE_ID_WIDTH 6
`endif

module tb_rpu_or_arb;

  localparam int N       = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int TW      = `NOU_TYPE_WIDTH;
  localparam int EW      = `NOU_ERR_CODE_WIDTH;
  localparam int IW      = `NOU_TID_WIDTH;
  localparam int LW      = `NOU_TILE_ID_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_vld = '0;
  logic [N*TW-1:0] req_type = '0;
  logic [N-1:0]    req_status = '0;
  logic [N*EW-1:0] req_err = '0;
  logic [N*IW-1:0] req_tid = '0;
  logic [N*LW-1:0] req_tile = '0;
  logic [N-1:0]    req_ack;
  logic            noc_rsp_rdy = 1'b0;
  logic            ob_rsp_vld;
  logic [TW-1:0]   ob_rsp_type;
  logic            ob_rsp_status;
  logic [EW-1:0]   ob_rsp_err;
  logic [IW-1:0]   cur_trans_id;
  logic [LW-1:0]   cur_dst_tile_id;
  logic [CNT_W-1:0] err_rsp_cnt;

  rpu_or_arb #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_type(req_type), .req_status(req_status),
    .req_err(req_err), .req_tid(req_tid), .req_tile(req_tile),
    .req_ack(req_ack), .noc_rsp_rdy(noc_rsp_rdy),
    .ob_rsp_vld(ob_rsp_vld), .ob_rsp_type(ob_rsp_type),
    .ob_rsp_status(ob_rsp_status), .ob_rsp_err(ob_rsp_err),
    .cur_trans_id(cur_trans_id), .cur_dst_tile_id(cur_dst_tile_id),
    .err_rsp_cnt(err_rsp_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- source-side driver ----------------
  logic          s_vld[N];
  logic [TW-1:0] s_type[N];
  logic          s_st[N];
  logic [EW-1:0] s_err[N];
  logic [IW-1:0] s_tid[N];
  logic [LW-1:0] s_tile[N];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i]            = s_vld[i];
      req_status[i]         = s_st[i];
      req_type[i*TW +: TW]  = s_type[i];
      req_err[i*EW +: EW]   = s_err[i];
      req_tid[i*IW +: IW]   = s_tid[i];
      req_tile[i*LW +: LW]  = s_tile[i];
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic st, input int ty,
                         input int tid, input int tile);
    s_vld[i]  = v;
    s_st[i]   = st;
    s_type[i] = TW'(ty);
    s_err[i]  = EW'(tid + 1);
    s_tid[i]  = IW'(tid);
    s_tile[i] = LW'(tile);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 1'b0, 0, 0, 0);
    drive();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // The model holds at most one response; it is replaced when the NoC takes
  // it and a new request exists, and dropped otherwise.
  bit            m_hold;
  int            m_ptr;
  int            m_cnt;
  logic [TW-1:0] m_type;
  logic          m_st;
  logic [EW-1:0] m_err;
  logic [IW-1:0] m_tid;
  logic [LW-1:0] m_tile;
  logic [N-1:0]  m_ack_last;

  initial begin
    m_hold = 0; m_ptr = 0; m_cnt = 0; m_ack_last = '0;
    m_type = '0; m_st = 1'b0; m_err = '0; m_tid = '0; m_tile = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_vld", 32'(ob_rsp_vld), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_cnt", 32'(err_rsp_cnt), 0);
        chk("rst_tid", 32'(cur_trans_id), 0);
        chk("rst_tile", 32'(cur_dst_tile_id), 0);
        chk("rst_type", 32'(ob_rsp_type), 0);
        chk("rst_err", 32'({ob_rsp_status, ob_rsp_err}), 0);
        m_hold = 0; m_ptr = 0; m_cnt = 0; m_ack_last = '0;
        m_type = '0; m_st = 1'b0; m_err = '0; m_tid = '0; m_tile = '0;
      end else begin
        logic [N-1:0] pool;
        logic [N-1:0] exp_ack;
        int           win;
        bit           can;
        pool = req_vld;
`ifdef NOU_OR_ARB_ERR_PRIO_EN
        if ((req_vld & req_status) != '0) pool = req_vld & req_status;
`endif
        win = -1;
        for (int k = 0; k < N; k++) begin
          if (win < 0 && pool[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        can = !m_hold || noc_rsp_rdy;
        exp_ack = '0;
        if (can && win >= 0) exp_ack[win] = 1'b1;

        chk("ack", 32'(req_ack), 32'(exp_ack));
        chk("vld", 32'(ob_rsp_vld), 32'(m_hold));
        chk("cnt", 32'(err_rsp_cnt), 32'(m_cnt));
        if (m_hold) begin
          chk("type", 32'(ob_rsp_type), 32'(m_type));
          chk("status", 32'(ob_rsp_status), 32'(m_st));
          chk("err", 32'(ob_rsp_err), 32'(m_err));
          chk("tid", 32'(cur_trans_id), 32'(m_tid));
          chk("tile", 32'(cur_dst_tile_id), 32'(m_tile));
        end

        if (m_hold && noc_rsp_rdy && m_st && m_cnt < CNT_MAX) m_cnt++;
        if (can && win >= 0) begin
          m_hold = 1;
          m_type = req_type[win*TW +: TW];
          m_st   = req_status[win];
          m_err  = req_err[win*EW +: EW];
          m_tid  = req_tid[win*IW +: IW];
          m_tile = req_tile[win*LW +: LW];
          m_ptr  = (win + 1) % N;
        end else if (m_hold && noc_rsp_rdy) begin
          m_hold = 0;
        end
        m_ack_last = exp_ack;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] exp_seq[5];

  initial begin
    clear_all();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Single request from source 2, then ptr=3 wrap test with sources 0 and 3.
    noc_rsp_rdy = 1'b1;
    set_src(2, 1'b1, 1'b0, 3, 'h15, 7); drive();
    @(negedge clk); chk("t1_ack", 32'(req_ack), 32'h4);
    next_cycle(); set_src(2, 1'b0, 1'b0, 0, 0, 0); drive();
    @(negedge clk);
    chk("t1_vld", 32'(ob_rsp_vld), 1);
    chk("t1_tid", 32'(cur_trans_id), 32'h15);
    chk("t1_tile", 32'(cur_dst_tile_id), 7);
    chk("t1_type", 32'(ob_rsp_type), 3);
    next_cycle();
    @(negedge clk); chk("t1_idle", 32'(ob_rsp_vld), 0);
    next_cycle();
    set_src(0, 1'b1, 1'b0, 1, 'h20, 1); set_src(3, 1'b1, 1'b0, 2, 'h33, 3); drive();
    @(negedge clk); chk("t4_ack_wrap", 32'(req_ack), 32'h8);
    next_cycle(); set_src(3, 1'b0, 1'b0, 0, 0, 0); drive();
    @(negedge clk); chk("t4_ack_next", 32'(req_ack), 32'h1);
    next_cycle(); clear_all();
    @(negedge clk); chk("t4_tid", 32'(cur_trans_id), 32'h20);
    next_cycle();

    // All sources continuously requesting: 0,1,2,3,0 back to back.
    do_reset();
    exp_seq[0] = 4'h1; exp_seq[1] = 4'h2; exp_seq[2] = 4'h4;
    exp_seq[3] = 4'h8; exp_seq[4] = 4'h1;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b0, i, 'h40 + i, i);
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_ack", 32'(req_ack), 32'(exp_seq[c]));
      if (c > 0) chk("t2_vld", 32'(ob_rsp_vld), 1);
      next_cycle();
    end
    clear_all();
    next_cycle(); next_cycle();

    // Backpressure: source 1 held for 5 cycles while source 3 waits.
    do_reset();
    noc_rsp_rdy = 1'b0;
    set_src(1, 1'b1, 1'b0, 5, 'h51, 9); drive();
    @(negedge clk); chk("t3_ack_load", 32'(req_ack), 32'h2);
    next_cycle();
    set_src(1, 1'b0, 1'b0, 0, 0, 0); set_src(3, 1'b1, 1'b0, 6, 'h63, 4); drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_ack_hold", 32'(req_ack), 0);
      chk("t3_vld_hold", 32'(ob_rsp_vld), 1);
      chk("t3_tid_hold", 32'(cur_trans_id), 32'h51);
      next_cycle();
    end
    noc_rsp_rdy = 1'b1;
    @(negedge clk); chk("t3_ack_rel", 32'(req_ack), 32'h8);
    next_cycle(); clear_all();
    next_cycle(); next_cycle();

    // Error priority: source 0 normal vs source 2 error.
    do_reset();
    set_src(0, 1'b1, 1'b0, 1, 'h01, 1); set_src(2, 1'b1, 1'b1, 2, 'h02, 2); drive();
    @(negedge clk);
`ifdef NOU_OR_ARB_ERR_PRIO_EN
    chk("t5_prio", 32'(req_ack), 32'h4);
`else
    chk("t5_prio", 32'(req_ack), 32'h1);
`endif
    next_cycle(); clear_all();
    next_cycle(); next_cycle(); next_cycle();

    // Counter saturation with continuous error responses, then async reset.
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, i, 'h80 + i, i);
    drive();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 15) chk("t6_cnt14", 32'(err_rsp_cnt), 14);
      if (c == 20) chk("t6_cnt_sat", 32'(err_rsp_cnt), CNT_MAX);
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(ob_rsp_vld), 0);
    chk("t6_rst_cnt", 32'(err_rsp_cnt), 0);
    chk("t6_rst_ack", 32'(req_ack), 0);
    next_cycle(); next_cycle();
    clear_all();
    rst_n = 1'b1;
    next_cycle();

    // Randomized traffic; sources drop a request after the model's ack.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack_last[i]) s_vld[i] = 1'b0;
        if (!s_vld[i] && $urandom_range(0, 2) == 0) begin
          set_src(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 63)));
        end
      end
      drive();
      noc_rsp_rdy = ($urandom_range(0, 3) != 0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
